// File: rtl/safe_zone_ctrl_if.sv
// safe_zone_ctrl_if: tracker-facing signal bundle of the safe-zone round generator
interface safe_zone_ctrl_if #(
  parameter int X_WIDTH = 10,
  parameter int RATING_WIDTH = 8,
  parameter int TICK_WIDTH = 8
);
  logic i_tick;
  logic i_pause;
  logic i_restart;
  logic [RATING_WIDTH-1:0] i_rating;
  logic [X_WIDTH-1:0] i_player_x;
  logic o_ready;
  logic o_round_ended;
  logic o_is_win;
  logic [X_WIDTH-1:0] o_zone_left;
  logic [X_WIDTH-1:0] o_zone_right;
  logic [TICK_WIDTH-1:0] o_time_left;
  modport master (
    output i_tick, i_pause, i_restart, i_rating, i_player_x,
    input o_ready, o_round_ended, o_is_win, o_zone_left, o_zone_right, o_time_left
  );
  modport slave (
    input i_tick, i_pause, i_restart, i_rating, i_player_x,
    output o_ready, o_round_ended, o_is_win, o_zone_left, o_zone_right, o_time_left
  );
endinterface

// File: rtl/safe_zone_ctrl.sv
// safe_zone_ctrl: LFSR safe-zone generator, rating-scaled countdown and round judge
module safe_zone_ctrl #(
  parameter int X_WIDTH = 10,
  parameter int SCREEN_W = 640,
  parameter int ZONE_W = 64,
  parameter int RATING_WIDTH = 8,
  parameter int TICK_WIDTH = 8,
  parameter int BASE_TICKS = 180,
  parameter int STEP_TICKS = 8,
  parameter int MIN_TICKS = 30
) (
  input logic clk,
  input logic rst,
  safe_zone_ctrl_if.slave sz
);
  localparam int DW = RATING_WIDTH + TICK_WIDTH + 1;
  typedef enum logic [1:0] {GEN, RUN, JUDGE, OVER} state_t;
  state_t state;
  logic [15:0] lfsr;
  logic [X_WIDTH-1:0] cand;
  logic [DW-1:0] prod, diff, dur;
  logic accept, win, tick_run;
  always_comb begin
    cand = lfsr[X_WIDTH-1:0];
    prod = DW'(sz.i_rating) * DW'(STEP_TICKS);
    diff = DW'(BASE_TICKS) - prod;
    dur = (prod > DW'(BASE_TICKS) || diff < DW'(MIN_TICKS)) ? DW'(MIN_TICKS) : diff;
    accept = state == GEN && !sz.i_pause && cand <= X_WIDTH'(SCREEN_W - ZONE_W);
    win = sz.i_player_x >= sz.o_zone_left && sz.i_player_x <= sz.o_zone_right;
    tick_run = state == RUN && sz.i_tick && !sz.i_pause;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= GEN;
      lfsr <= 16'hACE1;
      sz.o_ready <= 1'b0;
      sz.o_round_ended <= 1'b0;
      sz.o_is_win <= 1'b0;
      sz.o_zone_left <= '0;
      sz.o_zone_right <= X_WIDTH'(ZONE_W - 1);
      sz.o_time_left <= '0;
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      sz.o_ready <= accept;
      sz.o_round_ended <= state == JUDGE && !sz.i_pause;
      if (accept) begin
        sz.o_zone_left <= cand;
        sz.o_zone_right <= cand + X_WIDTH'(ZONE_W - 1);
        sz.o_time_left <= TICK_WIDTH'(dur);
        state <= RUN;
      end
      if (tick_run) begin
        sz.o_time_left <= sz.o_time_left - TICK_WIDTH'(1);
        if (sz.o_time_left == TICK_WIDTH'(1)) state <= JUDGE;
      end
      if (state == JUDGE && !sz.i_pause) begin
        sz.o_is_win <= win;
        state <= win ? GEN : OVER;
      end
      if (state == OVER && sz.i_restart) state <= GEN;
    end
  end
endmodule

// File: tb/tb_safe_zone_ctrl.sv
// tb_safe_zone_ctrl: randomized round-level checks against a behavioural model
module tb_safe_zone_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  safe_zone_ctrl_if sz();
  safe_zone_ctrl dut (.clk(clk), .rst(rst), .sz(sz.slave));
  int n_chk = 0;
  int n_pass = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic prev_win = 1'b0;
  int exp_left, exp_time;
  logic [9:0] px;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask
  function automatic logic [15:0] lfsr_next(logic [15:0] s);
    return {^(s & 16'h002D), s[15:1]};
  endfunction
  function automatic int duration(int r);
    int d = 180 - r * 8;
    return d < 30 ? 30 : d;
  endfunction
  task automatic cycle();
    @(posedge clk);
    m_lfsr = rst ? 16'hACE1 : lfsr_next(m_lfsr);
    #1;
  endtask
  task automatic check_reset(string tag);
    chk({tag, "_ready"}, sz.o_ready, 0);
    chk({tag, "_ended"}, sz.o_round_ended, 0);
    chk({tag, "_win"}, sz.o_is_win, 0);
    chk({tag, "_left"}, sz.o_zone_left, 0);
    chk({tag, "_right"}, sz.o_zone_right, 63);
    chk({tag, "_time"}, sz.o_time_left, 0);
  endtask
  task automatic gen_phase(int rating, int ppct, output bit ok);
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      bit p = $urandom_range(99) < ppct;
      logic [9:0] c = m_lfsr[9:0];
      bit acc = !p && c <= 576;
      sz.i_pause = p;
      sz.i_tick = $urandom_range(1);
      sz.i_restart = $urandom_range(1);
      sz.i_rating = acc ? 8'(rating) : 8'($urandom);
      cycle();
      chk("gen_ready", sz.o_ready, acc);
      chk("gen_ended", sz.o_round_ended, 0);
      if (acc) begin
        ok = 1;
        exp_left = c;
        exp_time = duration(rating);
        chk("gen_left", sz.o_zone_left, exp_left);
        chk("gen_right", sz.o_zone_right, exp_left + 63);
        chk("gen_time", sz.o_time_left, exp_time);
      end
    end
    if (!ok) chk("gen_timeout", 0, 1);
  endtask
  task automatic run_phase(int mode, int ppct, int rst_at, output bit aborted);
    int t = exp_time;
    aborted = 0;
    px = mode == 0 ? 10'(exp_left) : mode == 1 ? 10'(exp_left + 63) :
         mode == 2 ? 10'(exp_left + 64) : mode == 3 ? 10'(exp_left - 1) : 10'($urandom_range(639));
    sz.i_player_x = px;
    for (int i = 0; i < 2000 && t > 0; i++) begin
      bit p = $urandom_range(99) < ppct;
      bit k = $urandom_range(3) != 0;
      if (t == rst_at) begin
        rst = 1'b1;
        sz.i_pause = p;
        sz.i_tick = k;
        cycle();
        rst = 1'b0;
        check_reset("midrst");
        prev_win = 0;
        aborted = 1;
        return;
      end
      sz.i_pause = p;
      sz.i_tick = k;
      sz.i_restart = $urandom_range(1);
      cycle();
      if (k && !p) t--;
      chk("run_time", sz.o_time_left, t);
      chk("run_ready", sz.o_ready, 0);
      chk("run_ended", sz.o_round_ended, 0);
      chk("run_left", sz.o_zone_left, exp_left);
    end
    if (t > 0) chk("run_timeout", 0, 1);
  endtask
  task automatic judge_phase(output bit w);
    bit done = 0;
    w = int'(px) >= exp_left && int'(px) <= exp_left + 63;
    for (int i = 0; i < 300 && !done; i++) begin
      bit p = $urandom_range(1);
      sz.i_pause = p;
      sz.i_tick = $urandom_range(1);
      sz.i_restart = $urandom_range(1);
      cycle();
      chk("judge_ready", sz.o_ready, 0);
      if (!p) begin
        chk("judge_ended", sz.o_round_ended, 1);
        chk("judge_win", sz.o_is_win, w);
        prev_win = w;
        done = 1;
      end else begin
        chk("judge_held", sz.o_round_ended, 0);
        chk("judge_prev_win", sz.o_is_win, prev_win);
      end
    end
    if (!done) chk("judge_timeout", 0, 1);
  endtask
  task automatic over_phase();
    int n = $urandom_range(1, 10);
    for (int i = 0; i < n; i++) begin
      sz.i_restart = 0;
      sz.i_pause = $urandom_range(1);
      sz.i_tick = $urandom_range(1);
      cycle();
      chk("over_ready", sz.o_ready, 0);
      chk("over_ended", sz.o_round_ended, 0);
      chk("over_win", sz.o_is_win, 0);
    end
    sz.i_restart = 1;
    sz.i_pause = 0;
    cycle();
    chk("restart_ready", sz.o_ready, 0);
    sz.i_restart = 0;
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int r_tab[8] = '{0, 0, 10, 19, 255, 0, 5, 2};
    int m_tab[8] = '{0, 1, 2, 0, 1, 0, 3, 4};
    int p_tab[8] = '{0, 10, 10, 20, 20, 10, 30, 15};
    int s_tab[8] = '{-1, -1, -1, -1, -1, 50, -1, -1};
    bit ok, ab, w;
    sz.i_tick = 0;
    sz.i_pause = 0;
    sz.i_restart = 0;
    sz.i_rating = 0;
    sz.i_player_x = 0;
    repeat (3) cycle();
    check_reset("reset");
    rst = 1'b0;
    for (int r = 0; r < 16; r++) begin
      int rating = r < 8 ? r_tab[r] : int'($urandom_range(255));
      int mode = r < 8 ? m_tab[r] : int'($urandom_range(4));
      int ppct = r < 8 ? p_tab[r] : 15;
      int rst_at = r < 8 ? s_tab[r] : -1;
      gen_phase(rating, ppct, ok);
      if (!ok) continue;
      run_phase(mode, ppct, rst_at, ab);
      if (ab) continue;
      judge_phase(w);
      if (!w) over_phase();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
